// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for pipeline hazard control.
// MDU state encoding, default latency and register-zero id.
package pipe_ctrl_pkg;
  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  localparam int MDU_LAT_DEF = 32;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/hazard_ctrl_if.sv
// MDU sequencing bundle between hazard logic and tracker.
// Master issues start; slave reports busy/done.
interface hazard_ctrl_if;
  logic start;
  logic busy;
  logic done;

  modport master (
    output start,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    output busy,
    output done
  );
endinterface

// File: rtl/hazard_ctrl_mdu_tracker.sv
// Multiply/divide occupancy tracker: IDLE/BUSY FSM
// with a down-counter loaded on start.
import pipe_ctrl_pkg::*;

module mdu_tracker #(
  parameter int MDU_LAT = MDU_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  hazard_ctrl_if.slave mdu
);
  localparam int CW = $clog2(MDU_LAT);

  mdu_state_e r_state;
  mdu_state_e w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= MDU_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Counter runs free in BUSY; stalls never freeze it.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    mdu.busy    = 1'b0;
    mdu.done    = 1'b0;
    unique case (r_state)
      MDU_IDLE: begin
        if (mdu.start) begin
          w_state_nxt = MDU_BUSY;
          w_cnt_nxt   = CW'(MDU_LAT - 1);
        end
      end
      MDU_BUSY: begin
        mdu.busy = 1'b1;
        if (r_cnt == '0) begin
          mdu.done    = 1'b1;
          w_state_nxt = MDU_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: w_state_nxt = MDU_IDLE;
    endcase
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard priority: memory wait, branch flush,
// then load-use / MDU interlock; saturating stall counter.
import pipe_ctrl_pkg::*;

module hazard_ctrl #(
  parameter int MDU_LAT = MDU_LAT_DEF,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic             id_mdu_op,
  input  logic             id_mdu_read,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             stall_ifid,
  output logic             flush_ifid,
  output logic             stall_idex,
  output logic             flush_idex,
  output logic             stall_exmem,
  output logic             stall_memwb,
  output logic             mdu_start,
  output logic             mdu_busy,
  output logic             mdu_done,
  output logic [CNT_W-1:0] stall_count
);
  hazard_ctrl_if u_mdu_if ();

  logic w_mem_wait;
  logic w_load_use;
  logic w_mdu_ilk;
  logic w_hazard;
  logic [CNT_W-1:0] r_stall_cnt;

  assign w_mem_wait = dmem_req & ~dmem_ready;
  assign w_load_use = ex_memread
                    & (ex_rt != REG_ZERO)
                    & ((ex_rt == id_rs) | (ex_rt == id_rt));
  assign w_mdu_ilk  = u_mdu_if.busy
                    & (id_mdu_op | id_mdu_read);
  assign w_hazard   = w_mem_wait | ex_branch_taken
                    | w_load_use | w_mdu_ilk;

  always_comb begin
    pc_stall    = 1'b0;
    stall_ifid  = 1'b0;
    flush_ifid  = 1'b0;
    stall_idex  = 1'b0;
    flush_idex  = 1'b0;
    stall_exmem = 1'b0;
    stall_memwb = 1'b0;
    if (w_mem_wait) begin
      pc_stall    = 1'b1;
      stall_ifid  = 1'b1;
      stall_idex  = 1'b1;
      stall_exmem = 1'b1;
      stall_memwb = 1'b1;
    end else if (ex_branch_taken) begin
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (w_load_use | w_mdu_ilk) begin
      pc_stall   = 1'b1;
      stall_ifid = 1'b1;
      flush_idex = 1'b1;
    end
  end

  // Start only from IDLE in a clean cycle; tracker gates on IDLE.
  assign u_mdu_if.start = id_mdu_op & ~w_hazard & ~reset;

  mdu_tracker #(
    .MDU_LAT(MDU_LAT)
  ) u_mdu (
    .clk  (clk),
    .reset(reset),
    .mdu  (u_mdu_if)
  );

  assign mdu_start = u_mdu_if.start & ~u_mdu_if.busy;
  assign mdu_busy  = u_mdu_if.busy;
  assign mdu_done  = u_mdu_if.done;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (pc_stall && !(&r_stall_cnt)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_count = r_stall_cnt;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl with MDU_LAT=4, CNT_W=4.
// Driver queues expectations; negedge monitor compares.
module tb_hazard_ctrl;
  localparam int LAT = 4;
  localparam int CW  = 4;

  localparam logic [9:0] NONE = 10'b0000000000;
  localparam logic [9:0] LU   = 10'b1100100000;
  localparam logic [9:0] BR   = 10'b0010100000;
  localparam logic [9:0] MW   = 10'b1101011000;
  localparam logic [9:0] ST   = 10'b0000000100;
  localparam logic [9:0] BSY  = 10'b0000000010;
  localparam logic [9:0] DN   = 10'b0000000001;

  typedef struct {
    logic [9:0]    vec;
    logic [CW-1:0] cnt;
    string         nm;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic ex_memread, ex_branch_taken;
  logic id_mdu_op, id_mdu_read;
  logic dmem_req, dmem_ready;
  logic pc_stall, stall_ifid, flush_ifid;
  logic stall_idex, flush_idex;
  logic stall_exmem, stall_memwb;
  logic [CW-1:0] stall_count;

  hazard_ctrl_if mon_if ();

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .MDU_LAT(LAT),
    .CNT_W  (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .ex_memread     (ex_memread),
    .ex_rt          (ex_rt),
    .ex_branch_taken(ex_branch_taken),
    .id_mdu_op      (id_mdu_op),
    .id_mdu_read    (id_mdu_read),
    .dmem_req       (dmem_req),
    .dmem_ready     (dmem_ready),
    .pc_stall       (pc_stall),
    .stall_ifid     (stall_ifid),
    .flush_ifid     (flush_ifid),
    .stall_idex     (stall_idex),
    .flush_idex     (flush_idex),
    .stall_exmem    (stall_exmem),
    .stall_memwb    (stall_memwb),
    .mdu_start      (mon_if.start),
    .mdu_busy       (mon_if.busy),
    .mdu_done       (mon_if.done),
    .stall_count    (stall_count)
  );

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [9:0] got;
      e = exp_q.pop_front();
      got = {pc_stall, stall_ifid, flush_ifid,
             stall_idex, flush_idex,
             stall_exmem, stall_memwb,
             mon_if.start, mon_if.busy, mon_if.done};
      checks++;
      if (got !== e.vec) begin
        errors++;
        $display("FAIL %s ctrl got=%b want=%b",
                 e.nm, got, e.vec);
      end
      checks++;
      if (stall_count !== e.cnt) begin
        errors++;
        $display("FAIL %s stall_count got=%0d want=%0d",
                 e.nm, stall_count, e.cnt);
      end
    end
  end

  task automatic cyc(
    input logic       rst,
    input logic [4:0] rs, rt,
    input logic       mr,
    input logic [4:0] ert,
    input logic       br, op, rd, rq, rdy,
    input logic [9:0] ev,
    input int         ec,
    input string      nm
  );
    exp_t e;
    @(posedge clk);
    #1;
    reset           = rst;
    id_rs           = rs;
    id_rt           = rt;
    ex_memread      = mr;
    ex_rt           = ert;
    ex_branch_taken = br;
    id_mdu_op       = op;
    id_mdu_read     = rd;
    dmem_req        = rq;
    dmem_ready      = rdy;
    e.vec = ev;
    e.cnt = CW'(ec);
    e.nm  = nm;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [9:0] ev,
                      input int ec, input string nm);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, ev, ec, nm);
  endtask

  initial begin
    reset = 1'b1;
    id_rs = 0; id_rt = 0; ex_rt = 0;
    ex_memread = 0; ex_branch_taken = 0;
    id_mdu_op = 0; id_mdu_read = 0;
    dmem_req = 0; dmem_ready = 1;
    @(posedge clk);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, NONE, 0, "rst_idle");
    cyc(1, 5, 0, 1, 5, 0, 0, 0, 0, 1, LU, 0, "rst_lu");
    idle(NONE, 0, "post_rst");
    cyc(0, 5, 0, 1, 5, 0, 0, 0, 0, 1, LU, 0, "lu_rs");
    idle(NONE, 1, "lu_cnt");
    cyc(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, NONE, 1, "lu_r0");
    cyc(0, 3, 7, 1, 7, 0, 0, 0, 0, 1, LU, 1, "lu_rt");
    cyc(0, 3, 4, 1, 7, 0, 0, 0, 0, 1, NONE, 2, "lu_miss");
    cyc(0, 5, 0, 1, 5, 1, 0, 0, 0, 1, BR, 2, "br_over_lu");
    idle(NONE, 2, "idle_a");
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, MW, 2 + i, "memwait_br");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, NONE, 5, "mem_ready");
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, ST, 5, "mdu_start");
    for (int i = 0; i < 3; i++)
      cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, LU | BSY, 5 + i, "mdu_ilk");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, LU | BSY | DN, 8, "mdu_done");
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, NONE, 9, "mdu_release");
    idle(NONE, 9, "idle_b");
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, ST, 9, "start2");
    cyc(0, 0, 0, 0, 0, 1, 0, 0, 0, 1, BR | BSY, 9, "busy_br");
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MW | BSY, 9, "busy_mw");
    idle(BSY, 10, "busy3");
    idle(BSY | DN, 10, "busy4_done");
    idle(NONE, 10, "idle_c");
    cyc(0, 6, 0, 1, 6, 0, 1, 0, 0, 1, LU, 10, "start_blocked");
    idle(NONE, 11, "idle_d");
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 1, ST, 11, "start3");
    idle(BSY, 11, "busy_c1");
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, BSY, 11, "rst_in_busy");
    idle(NONE, 0, "abandon0");
    idle(NONE, 0, "abandon1");
    idle(NONE, 0, "abandon2");
    idle(NONE, 0, "abandon3");
    for (int i = 0; i < (1 << CW) + 3; i++)
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MW,
          (i > 15) ? 15 : i, "sat_mw");
    cyc(0, 9, 0, 1, 9, 0, 0, 0, 0, 1, LU, 15, "sat_lu");
    idle(NONE, 15, "sat_hold");
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d want=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MDU_LAT, default 32, giving the multiply/divide occupancy in cycles (legal range 2..63).
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of the stall performance counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports id_rs and id_rt, input, 5 bits each: source registers of the instruction in ID.
REQ-006 SHALL have ports ex_memread (1 bit) and ex_rt (5 bits), inputs: the load in EX and its destination.
REQ-007 SHALL have port ex_branch_taken, input, 1 bit: branch or jump resolved taken in EX.
REQ-008 SHALL have ports id_mdu_op and id_mdu_read, inputs, 1 bit each: ID holds a mult/div, or an mfhi/mflo.
REQ-009 SHALL have ports dmem_req and dmem_ready, inputs, 1 bit each: MEM-stage access handshake.
REQ-010 SHALL have port pc_stall, output, 1 bit: hold the PC.
REQ-011 SHALL have ports stall_ifid, flush_ifid, stall_idex, flush_idex, stall_exmem, stall_memwb, outputs, 1 bit each: controls for the pipeline registers (flush loads zero bubble when not stalled).
REQ-012 SHALL have ports mdu_start, mdu_busy and mdu_done, outputs, 1 bit each: MDU sequencing.
REQ-013 SHALL have port stall_count, output, CNT_W bits: cycles with pc_stall=1, saturating.

Function
REQ-014 SHALL evaluate hazards combinationally each cycle in priority order: memory wait, then branch flush, then load-use/MDU interlock.
REQ-015 Memory wait (dmem_req=1, dmem_ready=0) SHALL assert pc_stall and all four stall_* outputs, with all flush_* outputs at 0.
REQ-016 Branch flush (ex_branch_taken=1, no memory wait) SHALL assert flush_ifid and flush_idex with all stalls at 0, overriding any interlock in the same cycle.
REQ-017 Load-use SHALL be detected when ex_memread=1, ex_rt!=0, and ex_rt equals id_rs or id_rt.
REQ-018 Load-use SHALL assert pc_stall, stall_ifid and flush_idex; EX/MEM and MEM/WB advance.
REQ-019 MDU interlock SHALL be detected when mdu_busy=1 and (id_mdu_op=1 or id_mdu_read=1), and SHALL produce the same outputs as load-use.
REQ-020 The MDU FSM SHALL have states IDLE and BUSY, plus a down-counter of ceil(log2(MDU_LAT)) bits.
REQ-021 IDLE->BUSY: mdu_start SHALL be 1 exactly when state=IDLE, id_mdu_op=1, and no hazard of REQ-015..019 is active; on that edge the counter loads MDU_LAT-1.
REQ-022 In BUSY the counter SHALL decrement every cycle regardless of stalls or flushes; mdu_busy SHALL be 1.
REQ-023 In BUSY with count=0, mdu_done SHALL be 1 for that cycle and the next state SHALL be IDLE; mdu_busy stays 1 in that cycle.
REQ-024 A branch flush or memory wait SHALL NOT abort an MDU operation already in BUSY.
REQ-025 stall_count SHALL increment by 1 on each edge with pc_stall=1 and hold at all-ones.

Reset
REQ-026 While reset=1 at an edge: state becomes IDLE, the counter becomes 0, and stall_count becomes 0.
REQ-027 Reset during BUSY SHALL abandon the operation with no mdu_done pulse.
REQ-028 During reset all outputs SHALL follow REQ-014..019 combinationally from the inputs, with mdu_busy=0, mdu_start=0 and mdu_done=0 after the reset edge.

Structure
REQ-029 Package pipe_ctrl_pkg SHALL hold the MDU state enum, the default MDU_LAT, and the register-zero constant.
REQ-030 The MDU FSM and counter SHALL be a sub-module named mdu_tracker; hazard priority logic and stall_count stay in hazard_ctrl.

Verification (MDU_LAT=4)
REQ-031 ex_memread=1, ex_rt=5, id_rs=5 for 1 cycle -> pc_stall=stall_ifid=flush_idex=1 and stall_count=1; with ex_rt=0 instead -> no stall.
REQ-032 Load-use and ex_branch_taken=1 together -> flush_ifid=flush_idex=1, pc_stall=0.
REQ-033 dmem_req=1, dmem_ready=0 for 3 cycles with ex_branch_taken=1 -> all stalls=1, flushes=0, stall_count=3.
REQ-034 id_mdu_op=1 in IDLE -> mdu_start=1, then mdu_busy=1 for 4 cycles with mdu_done in the 4th; id_mdu_read=1 throughout -> interlock for those 4 cycles, released in the 5th.
REQ-035 Reset asserted in the 2nd BUSY cycle -> next cycle IDLE with mdu_busy=0 and mdu_done never asserted.
REQ-036 pc_stall held for 2^CNT_W+3 cycles -> stall_count saturates at all-ones.
